// File: rtl/shift_serializer.sv
// Parallel-in, serial-out transmitter: accepts a WIDTH-bit word over valid/ready
// and shifts it out one bit per clock, MSB- or LSB-first, with frame strobe and done pulse.
module shift_serializer #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] data_in,
   input  logic             msb_first,
   input  logic             hold,
   output logic             sout,
   output logic             sframe,
   output logic             done
);

   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] shreg_q;
   logic [WIDTH-1:0] shreg_d;
   logic [CNT_W-1:0] cnt_q;
   logic             dir_q;
   logic             done_q;
   logic             last_bit;
   logic             accept;

   always_comb begin
      last_bit   = (state_q == SHIFT) && (cnt_q == '0) && !hold;
      // rst gates ready so the producer never sees a handshake while the block is held in reset
      load_ready = !rst && ((state_q == IDLE) || last_bit);
      accept     = load_valid && load_ready;
      shreg_d    = dir_q ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
         dir_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= last_bit;
         if (accept) begin
            state_q <= SHIFT;
            shreg_q <= data_in;
            dir_q   <= msb_first;
            cnt_q   <= CNT_W'(WIDTH - 1);
         end else if (state_q == SHIFT && !hold) begin
            if (cnt_q == '0) begin
               state_q <= IDLE;
            end else begin
               shreg_q <= shreg_d;
               cnt_q   <= cnt_q - CNT_W'(1);
            end
         end
      end
   end

   assign sframe = (state_q == SHIFT);
   assign sout   = sframe && (dir_q ? shreg_q[WIDTH-1] : shreg_q[0]);
   assign done   = done_q;

endmodule

// File: tb/tb_shift_serializer.sv
// Directed bench for shift_serializer: a bit-position model checked every cycle,
// plus literal frame contents and done counts for each scenario.
module tb_shift_serializer;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         load_valid;
   logic         load_ready;
   logic [W-1:0] data_in;
   logic         msb_first;
   logic         hold;
   logic         sout;
   logic         sframe;
   logic         done;

   shift_serializer #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
      .data_in(data_in), .msb_first(msb_first), .hold(hold),
      .sout(sout), .sframe(sframe), .done(done)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: current word, latched order and which bit position (0 = first sent) is on the wire
   logic         m_act;
   logic         m_dir;
   logic         m_done;
   logic [W-1:0] m_word;
   int           m_pos;
   wire          m_ready = !rst && (!m_act || (m_pos == W-1 && !hold));

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_act  <= 1'b0;
         m_done <= 1'b0;
         m_pos  <= 0;
         m_dir  <= 1'b0;
         m_word <= '0;
      end else begin
         m_done <= m_act && (m_pos == W-1) && !hold;
         if (load_valid && m_ready) begin
            m_act  <= 1'b1;
            m_word <= data_in;
            m_dir  <= msb_first;
            m_pos  <= 0;
         end else if (m_act && !hold) begin
            if (m_pos == W-1) m_act <= 1'b0;
            else m_pos <= m_pos + 1;
         end
      end
   end

   function automatic logic exp_sout();
      if (!m_act) return 1'b0;
      return m_dir ? m_word[W-1-m_pos] : m_word[m_pos];
   endfunction

   logic cap[$];
   int   n_done      = 0;
   int   n_done_fram = 0;

   always @(negedge clk) begin
      chk("sframe", 32'(sframe), 32'(m_act));
      chk("sout", 32'(sout), 32'(exp_sout()));
      chk("load_ready", 32'(load_ready), 32'(m_ready));
      chk("done", 32'(done), 32'(m_done));
      if (sframe) cap.push_back(sout);
      if (done) n_done++;
      if (done && sframe) n_done_fram++;
   end

   function automatic logic [31:0] cap_val();
      logic [31:0] v = '0;
      foreach (cap[i]) v = {v[30:0], cap[i]};
      return v;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_stats();
      cap.delete();
      n_done      = 0;
      n_done_fram = 0;
   endtask

   // Waits (bounded) for a handshake with load_valid already high; returns 1 ns after it
   task automatic wait_accept(input string name, input logic drop);
      bit ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (load_ready) begin
            @(posedge clk);
            #1;
            if (drop) load_valid = 1'b0;
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         n_chk++;
         n_fail++;
         $display("FAIL %s: no handshake within 40 cycles", name);
         load_valid = 1'b0;
      end
   endtask

   initial begin
      rst = 1'b1; load_valid = 1'b0; data_in = '0; msb_first = 1'b0; hold = 1'b0;
      @(negedge clk);
      chk("rst_ready", 32'(load_ready), 32'd0);
      chk("rst_sframe", 32'(sframe), 32'd0);
      tick(2);
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", 32'(load_ready), 32'd1);

      // 1: MSB-first 0xC1
      @(posedge clk); #1;
      clear_stats();
      load_valid = 1'b1; data_in = 8'hC1; msb_first = 1'b1;
      wait_accept("t1_acc", 1'b1);
      tick(10);
      chk("t1_bits", cap_val(), 32'hC1);
      chk("t1_len", 32'(cap.size()), 32'd8);
      chk("t1_done", 32'(n_done), 32'd1);

      // 2: LSB-first 0xC1, msb_first toggled mid-frame
      clear_stats();
      load_valid = 1'b1; data_in = 8'hC1; msb_first = 1'b0;
      wait_accept("t2_acc", 1'b1);
      tick(3); msb_first = 1'b1;
      tick(2); msb_first = 1'b0;
      tick(6);
      chk("t2_bits", cap_val(), 32'h83);
      chk("t2_len", 32'(cap.size()), 32'd8);
      chk("t2_done", 32'(n_done), 32'd1);

      // 3: hold for two edges while the third bit is on the wire
      clear_stats();
      load_valid = 1'b1; data_in = 8'hC1; msb_first = 1'b1;
      wait_accept("t3_acc", 1'b1);
      tick(2); hold = 1'b1;
      tick(2); hold = 1'b0;
      tick(10);
      chk("t3_bits", cap_val(), 32'h301);
      chk("t3_len", 32'(cap.size()), 32'd10);
      chk("t3_done", 32'(n_done), 32'd1);

      // 4: back-to-back frames with load_valid held
      clear_stats();
      load_valid = 1'b1; data_in = 8'hC1; msb_first = 1'b1;
      wait_accept("t4_acc1", 1'b0);
      data_in = 8'h0F;
      wait_accept("t4_acc2", 1'b1);
      tick(10);
      chk("t4_bits", cap_val(), 32'hC10F);
      chk("t4_len", 32'(cap.size()), 32'd16);
      chk("t4_done", 32'(n_done), 32'd2);
      chk("t4_done_in_frame", 32'(n_done_fram), 32'd1);

      // 5: asynchronous reset during bit 4
      clear_stats();
      load_valid = 1'b1; data_in = 8'hC1; msb_first = 1'b1;
      wait_accept("t5_acc", 1'b1);
      tick(3);
      #2 rst = 1'b1;
      #1;
      chk("t5_sout", 32'(sout), 32'd0);
      chk("t5_sframe", 32'(sframe), 32'd0);
      chk("t5_ready", 32'(load_ready), 32'd0);
      chk("t5_done", 32'(done), 32'd0);
      tick(2); rst = 1'b0;
      tick(3);
      chk("t5_partial", cap_val(), 32'h6);
      chk("t5_no_done", 32'(n_done), 32'd0);
      clear_stats();
      load_valid = 1'b1; data_in = 8'hFF; msb_first = 1'b0;
      wait_accept("t5_acc2", 1'b1);
      tick(10);
      chk("t5_ff", cap_val(), 32'hFF);
      chk("t5_ff_len", 32'(cap.size()), 32'd8);
      chk("t5_ff_done", 32'(n_done), 32'd1);

      // 6: load_valid raised during bit 3 waits for the last-bit cycle
      clear_stats();
      load_valid = 1'b1; data_in = 8'hC1; msb_first = 1'b1;
      wait_accept("t6_acc1", 1'b1);
      tick(2);
      load_valid = 1'b1; data_in = 8'h3C;
      @(negedge clk);
      chk("t6_ready_bit3", 32'(load_ready), 32'd0);
      wait_accept("t6_acc2", 1'b1);
      tick(10);
      chk("t6_bits", cap_val(), 32'hC13C);
      chk("t6_len", 32'(cap.size()), 32'd16);
      chk("t6_done", 32'(n_done), 32'd2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end
endmodule
